// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory stage: bus widths, RV64 funct3 codes, fault codes and FSM states.
package mem_access_unit_pkg;

    localparam int BUS_64  = 64;
    localparam int STRB_64 = BUS_64 / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_align_ext.sv
// Combinational size handling: byte strobes, store-lane shift, load extraction/extension,
// and misalignment / illegal-funct3 detection.
module mem_align_ext
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = BUS_64
) (
    input  logic [2:0]          funct3,
    input  logic [2:0]          addr_lo,
    input  logic                is_store,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata_sh,
    output logic [DATA_W-1:0]   rdata_ext,
    output logic                misalign,
    output logic                illegal
);

    localparam int STRB_W = DATA_W / 8;

    logic [5:0]        shamt;
    logic [DATA_W-1:0] rdata_sh;

    always_comb begin
        shamt    = {addr_lo, 3'b000};
        rdata_sh = rdata >> shamt;
        wdata_sh = wdata << shamt;
        wstrb    = '0;
        misalign = 1'b0;
        illegal  = is_store ? (funct3 > F3_SD) : (funct3 > F3_LWU);

        // The low two funct3 bits encode the access size for both loads and stores.
        case (funct3[1:0])
            F3_SB[1:0]: wstrb = STRB_W'(1) << addr_lo;
            F3_SH[1:0]: begin
                wstrb    = STRB_W'(3) << addr_lo;
                misalign = addr_lo[0];
            end
            F3_SW[1:0]: begin
                wstrb    = STRB_W'(15) << addr_lo;
                misalign = |addr_lo[1:0];
            end
            default: begin
                wstrb    = '1;
                misalign = |addr_lo;
            end
        endcase

        case (funct3)
            F3_LB:   rdata_ext = {{(DATA_W-8){rdata_sh[7]}},   rdata_sh[7:0]};
            F3_LH:   rdata_ext = {{(DATA_W-16){rdata_sh[15]}}, rdata_sh[15:0]};
            F3_LW:   rdata_ext = {{(DATA_W-32){rdata_sh[31]}}, rdata_sh[31:0]};
            F3_LD:   rdata_ext = rdata_sh;
            F3_LBU:  rdata_ext = {{(DATA_W-8){1'b0}},  rdata_sh[7:0]};
            F3_LHU:  rdata_ext = {{(DATA_W-16){1'b0}}, rdata_sh[15:0]};
            F3_LWU:  rdata_ext = {{(DATA_W-32){1'b0}}, rdata_sh[31:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory stage with req/gnt/rvalid data bus and valid/ready on both sides.
// Optional MEM_ACCESS_TIMEOUT_EN adds a read-response timeout that reports fault 11.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = BUS_64,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic                in_ren,
    input  logic                in_wen,
    input  logic [2:0]          in_funct3,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic [TAG_W-1:0]    out_tag,
    output logic [1:0]          out_fault,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    state_e state, next_state;

    logic [2:0]          funct3_q;
    logic [2:0]          addr_lo_q;
    logic                is_store_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          fault_q;
    logic                bus_we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [DATA_W/8-1:0] bus_wstrb_q;

    logic                in_is_load, in_is_store, in_is_mem, in_issue;
    logic [2:0]          ext_funct3, ext_addr_lo;
    logic                ext_is_store;
    logic [DATA_W/8-1:0] ext_wstrb;
    logic [DATA_W-1:0]   ext_wdata, ext_rdata;
    logic                ext_misalign, ext_illegal;
    logic                timed_out;

    // Both enables high counts as a load.
    assign in_is_load  = in_ren;
    assign in_is_store = in_wen & ~in_ren;
    assign in_is_mem   = in_is_load | in_is_store;
    assign in_issue    = in_is_mem & ~ext_illegal & ~ext_misalign;

    // IDLE decodes the incoming op; later states work on the latched one.
    assign ext_funct3   = (state == ST_IDLE) ? in_funct3   : funct3_q;
    assign ext_addr_lo  = (state == ST_IDLE) ? in_addr[2:0] : addr_lo_q;
    assign ext_is_store = (state == ST_IDLE) ? in_is_store : is_store_q;

    mem_align_ext #(.DATA_W(DATA_W)) u_align (
        .funct3    (ext_funct3),
        .addr_lo   (ext_addr_lo),
        .is_store  (ext_is_store),
        .wdata     (in_wdata),
        .rdata     (bus_rdata),
        .wstrb     (ext_wstrb),
        .wdata_sh  (ext_wdata),
        .rdata_ext (ext_rdata),
        .misalign  (ext_misalign),
        .illegal   (ext_illegal)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == ST_REQ && bus_gnt)
            wait_cnt <= '0;
        else if (state == ST_WAIT)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !bus_rvalid;
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        bus_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = in_issue ? ST_REQ : ST_DONE;
            end
            ST_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt)
                    next_state = is_store_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_rvalid || timed_out)
                    next_state = ST_DONE;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready)
                    next_state = ST_IDLE;
            end
        endcase
    end

    // Result and bus registers are loaded at acceptance and only touched again by the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            is_store_q  <= 1'b0;
            tag_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= FAULT_OK;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        funct3_q   <= in_funct3;
                        addr_lo_q  <= in_addr[2:0];
                        is_store_q <= in_is_store;
                        tag_q      <= in_tag;
                        rdata_q    <= in_is_mem ? '0 : in_wdata;
                        if (!in_is_mem)
                            fault_q <= FAULT_OK;
                        else if (ext_illegal)
                            fault_q <= FAULT_ILLEGAL;
                        else if (ext_misalign)
                            fault_q <= FAULT_MISALIGN;
                        else
                            fault_q <= FAULT_OK;
                        if (in_issue) begin
                            bus_we_q    <= in_is_store;
                            bus_addr_q  <= {in_addr[ADDR_W-1:3], 3'b000};
                            bus_wdata_q <= in_is_store ? ext_wdata : '0;
                            bus_wstrb_q <= in_is_store ? ext_wstrb : '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        rdata_q <= ext_rdata;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        fault_q <= FAULT_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_rdata = rdata_q;
    assign out_tag   = tag_q;
    assign out_fault = fault_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus hand sequences for
// back-pressure, reset mid-transaction and (with MEM_ACCESS_TIMEOUT_EN) the read timeout.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 4;
    localparam int NV      = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready;
    logic [ADDR_W-1:0]  in_addr;
    logic               in_ren, in_wen;
    logic [2:0]         in_funct3;
    logic [DATA_W-1:0]  in_wdata;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid, out_ready;
    logic [DATA_W-1:0]  out_rdata;
    logic [TAG_W-1:0]   out_tag;
    logic [1:0]         out_fault;
    logic               bus_req, bus_gnt, bus_we;
    logic [ADDR_W-1:0]  bus_addr;
    logic [DATA_W-1:0]  bus_wdata;
    logic [7:0]         bus_wstrb;
    logic               bus_rvalid;
    logic [DATA_W-1:0]  bus_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_ren(in_ren), .in_wen(in_wen), .in_funct3(in_funct3),
        .in_wdata(in_wdata), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_tag(out_tag), .out_fault(out_fault),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [63:0] addr;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] wdata;
        logic [4:0]  tag;
        logic [63:0] rdata;
        int          gnt_delay;
        int          rv_delay;
        logic        exp_bus;
        logic [63:0] exp_baddr;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_bwdata;
        logic [63:0] exp_rdata;
        logic [1:0]  exp_fault;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  tag;
        logic [1:0]  fault;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [63:0] addr, input logic ren, input logic wen,
                                input logic [2:0] f3, input logic [63:0] wdata, input logic [4:0] tag,
                                input logic [63:0] rdata, input int gd, input int rd,
                                input logic eb, input logic [63:0] baddr, input logic [7:0] strb,
                                input logic [63:0] bwdata, input logic [63:0] erd, input logic [1:0] ef);
        vec_t v;
        v.addr = addr; v.ren = ren; v.wen = wen; v.f3 = f3; v.wdata = wdata; v.tag = tag;
        v.rdata = rdata; v.gnt_delay = gd; v.rv_delay = rd;
        v.exp_bus = eb; v.exp_baddr = baddr; v.exp_wstrb = strb; v.exp_bwdata = bwdata;
        v.exp_rdata = erd; v.exp_fault = ef;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one op, plays the bus side, and queues the expected result unless abandoned.
    task automatic applyStimulus(input vec_t v, input bit abandon);
        int   cyc;
        exp_t e;
        in_addr = v.addr; in_ren = v.ren; in_wen = v.wen; in_funct3 = v.f3;
        in_wdata = v.wdata; in_tag = v.tag; in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("in_ready_offer", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.rdata = v.exp_rdata; e.tag = v.tag; e.fault = v.exp_fault;
        if (!abandon) sb_q.push_back(e);
        checkOutput("in_ready_busy", in_ready, 0);
        checkOutput("bus_req", bus_req, v.exp_bus);
        if (v.exp_bus) begin
            checkOutput("bus_addr", bus_addr, v.exp_baddr);
            checkOutput("bus_we", bus_we, v.wen & ~v.ren);
            if (v.wen && !v.ren) begin
                checkOutput("bus_wstrb", bus_wstrb, v.exp_wstrb);
                checkOutput("bus_wdata", bus_wdata, v.exp_bwdata);
            end
            for (int i = 0; i < v.gnt_delay; i++) begin
                @(posedge clk); #1;
                checkOutput("bus_req_held", bus_req, 1);
                checkOutput("bus_addr_held", bus_addr, v.exp_baddr);
                if (v.wen && !v.ren) checkOutput("bus_wstrb_held", bus_wstrb, v.exp_wstrb);
            end
            bus_gnt = 1'b1;
            @(posedge clk); #1;
            bus_gnt = 1'b0;
            checkOutput("bus_req_drop", bus_req, 0);
            if (v.wen && !v.ren) begin
                checkOutput("store_valid_after_gnt", out_valid, 1);
            end else if (!abandon) begin
                for (int i = 0; i < v.rv_delay; i++) begin
                    @(posedge clk); #1;
                    checkOutput("wait_no_valid", out_valid, 0);
                end
                bus_rdata = v.rdata; bus_rvalid = 1'b1;
                @(posedge clk); #1;
                bus_rvalid = 1'b0; bus_rdata = '0;
            end
        end
    endtask

    task automatic collectOutput(input int budget);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!out_valid && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL out_valid_wait: got 0, expected 1 within %0d cycles", budget);
        end else if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL scoreboard: got result tag 0x%0h, expected none", out_tag);
        end else begin
            e = sb_q.pop_front();
            checkOutput("out_rdata", out_rdata, e.rdata);
            checkOutput("out_tag", out_tag, e.tag);
            checkOutput("out_fault", out_fault, e.fault);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checkOutput("out_valid_after_hs", out_valid, 0);
            checkOutput("in_ready_after_hs", in_ready, 1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_ren = 1'b0; in_wen = 1'b0;
        in_funct3 = '0; in_wdata = '0; in_tag = '0; out_ready = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        //            addr            ren  wen  f3    wdata                   tag    rdata                   gd rd bus baddr          strb   bwdata                  exp_rdata               fault
        vecs[0]  = mk(64'h1003,       1'b1,1'b0,3'd0, 64'h0,                  5'd1,  64'h0000_0000_80FF_0000, 0, 1, 1'b1,64'h1000,      8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 2'b00);
        vecs[1]  = mk(64'h1003,       1'b1,1'b0,3'd4, 64'h0,                  5'd2,  64'h0000_0000_80FF_0000, 1, 0, 1'b1,64'h1000,      8'h00, 64'h0,                  64'h80,                  2'b00);
        vecs[2]  = mk(64'h2006,       1'b0,1'b1,3'd1, 64'hABCD,               5'd3,  64'h0,                   2, 0, 1'b1,64'h2000,      8'hC0, 64'hABCD_0000_0000_0000, 64'h0,                  2'b00);
        vecs[3]  = mk(64'h3002,       1'b1,1'b0,3'd2, 64'h0,                  5'd4,  64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'h0,                   2'b01);
        vecs[4]  = mk(64'h4000,       1'b1,1'b0,3'd7, 64'h0,                  5'd5,  64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'h0,                   2'b10);
        vecs[5]  = mk(64'h0,          1'b0,1'b0,3'd0, 64'h1234_5678_9ABC_DEF0, 5'd6, 64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'h1234_5678_9ABC_DEF0, 2'b00);
        vecs[6]  = mk(64'h100A,       1'b1,1'b0,3'd1, 64'h0,                  5'd7,  64'h1111_2222_F00D_3333, 1, 0, 1'b1,64'h1008,      8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_F00D, 2'b00);
        vecs[7]  = mk(64'h100A,       1'b1,1'b0,3'd5, 64'h0,                  5'd8,  64'h1111_2222_F00D_3333, 0, 2, 1'b1,64'h1008,      8'h00, 64'h0,                  64'hF00D,                2'b00);
        vecs[8]  = mk(64'h1004,       1'b1,1'b0,3'd2, 64'h0,                  5'd9,  64'h8765_4321_0000_0000, 0, 0, 1'b1,64'h1000,      8'h00, 64'h0,                  64'hFFFF_FFFF_8765_4321, 2'b00);
        vecs[9]  = mk(64'h1004,       1'b1,1'b0,3'd6, 64'h0,                  5'd10, 64'h8765_4321_0000_0000, 0, 0, 1'b1,64'h1000,      8'h00, 64'h0,                  64'h8765_4321,           2'b00);
        vecs[10] = mk(64'h2000,       1'b1,1'b0,3'd3, 64'h0,                  5'd11, 64'hDEAD_BEEF_CAFE_F00D, 3, 2, 1'b1,64'h2000,      8'h00, 64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 2'b00);
        vecs[11] = mk(64'h5005,       1'b0,1'b1,3'd0, 64'hEE,                 5'd12, 64'h0,                   0, 0, 1'b1,64'h5000,      8'h20, 64'h0000_EE00_0000_0000, 64'h0,                  2'b00);
        vecs[12] = mk(64'h6004,       1'b0,1'b1,3'd2, 64'h1122_3344,          5'd13, 64'h0,                   1, 0, 1'b1,64'h6000,      8'hF0, 64'h1122_3344_0000_0000, 64'h0,                  2'b00);
        vecs[13] = mk(64'h7008,       1'b0,1'b1,3'd3, 64'h0102_0304_0506_0708, 5'd14, 64'h0,                  0, 0, 1'b1,64'h7008,      8'hFF, 64'h0102_0304_0506_0708, 64'h0,                  2'b00);
        vecs[14] = mk(64'h6002,       1'b0,1'b1,3'd2, 64'h1,                  5'd15, 64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'h0,                   2'b01);
        vecs[15] = mk(64'h5000,       1'b0,1'b1,3'd4, 64'h1,                  5'd16, 64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'h0,                   2'b10);
        vecs[16] = mk(64'h1001,       1'b1,1'b0,3'd1, 64'h0,                  5'd17, 64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'h0,                   2'b01);
        vecs[17] = mk(64'h2004,       1'b1,1'b0,3'd3, 64'h0,                  5'd18, 64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'h0,                   2'b01);
        vecs[18] = mk(64'h8000,       1'b1,1'b1,3'd3, 64'h99,                 5'd19, 64'h55,                  0, 1, 1'b1,64'h8000,      8'h00, 64'h0,                  64'h55,                  2'b00);
        vecs[19] = mk(64'h3,          1'b0,1'b0,3'd7, 64'hCAFE,               5'd20, 64'h0,                   0, 0, 1'b0,64'h0,         8'h00, 64'h0,                  64'hCAFE,                2'b00);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_bus_req", bus_req, 0);
        checkOutput("rst_bus_we", bus_we, 0);
        checkOutput("rst_bus_wstrb", bus_wstrb, 0);
        checkOutput("rst_out_rdata", out_rdata, 0);
        checkOutput("rst_out_tag", out_tag, 0);
        checkOutput("rst_out_fault", out_fault, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i], 1'b0);
            collectOutput(30);
        end

        // Back-pressure: result must hold and a waiting op must not be taken; stray gnt is ignored.
        applyStimulus(vecs[10], 1'b0);
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        in_addr = vecs[5].addr; in_ren = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0;
        in_wdata = vecs[5].wdata; in_tag = vecs[5].tag; in_valid = 1'b1; bus_gnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_rdata", out_rdata, vecs[10].exp_rdata);
            checkOutput("bp_out_tag", out_tag, vecs[10].tag);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_bus_req", bus_req, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; bus_gnt = 1'b0;
        collectOutput(5);
        applyStimulus(vecs[5], 1'b0);
        collectOutput(5);

        // Reset while waiting for read data; the late response must vanish.
        applyStimulus(vecs[0], 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rstw_out_valid", out_valid, 0);
        checkOutput("rstw_in_ready", in_ready, 1);
        checkOutput("rstw_out_rdata", out_rdata, 0);
        checkOutput("rstw_out_tag", out_tag, 0);
        bus_rdata = 64'h0000_0000_80FF_0000; bus_rvalid = 1'b1;
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = '0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("rstw_no_result", out_valid, 0);
            checkOutput("rstw_no_req", bus_req, 0);
            @(posedge clk); #1;
        end
        applyStimulus(vecs[1], 1'b0);
        collectOutput(30);

`ifdef MEM_ACCESS_TIMEOUT_EN
        begin
            exp_t e;
            int   n;
            applyStimulus(vecs[8], 1'b1);
            e.rdata = 64'h0; e.tag = vecs[8].tag; e.fault = 2'b11;
            sb_q.push_back(e);
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("timeout_latency", n, TIMEOUT);
            collectOutput(5);
        end
`endif

        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
